// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that sequences four requesters onto the shared 4-input mux.
// Select and grant come from posedge registers, so they are stable at the mux's sampling negedge.
module mux4_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clock_in,
  input  logic             reset_signal,
  input  logic             enable_signal,
  input  logic [3:0]       req,
  output logic [3:0]       grant,
  output logic [1:0]       mux_select,
  output logic             mux_enable,
  output logic             busy,
  output logic [CNT_W-1:0] owner_cycles
);

  // Handshake: req[i] is a level held for as long as requester i wants the mux.
  // It is sampled at every posedge with enable_signal=1. A requester owns the mux
  // while grant[i]=1, and the mux is driven only while mux_enable=1.

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic [1:0]       last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       grant_q, grant_d;

  logic [1:0]       base;
  logic [1:0]       winner;
  logic             hold_hit;
  logic             release_now;

  // First requester after base, wrapping, with base itself searched last.
  function automatic logic [1:0] rr_pick(input logic [1:0] b, input logic [3:0] r);
    logic [1:0] idx;
    rr_pick = b;
    for (int k = 4; k >= 1; k--) begin
      idx = b + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign base        = (state_q == GRANT) ? owner_q : last_q;
  assign winner      = rr_pick(base, req);
  assign hold_hit    = (MAX_HOLD != 0) && (cnt_q == HOLD_LIM);
  assign release_now = !req[owner_q] || hold_hit;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    if (enable_signal) begin
      case (state_q)
        IDLE: begin
          if (req != 4'b0000) begin
            state_d = GRANT;
            owner_d = winner;
            last_d  = winner;
            cnt_d   = CNT_ONE;
            grant_d = 4'b0001 << winner;
          end
        end
        GRANT: begin
          if (!release_now) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
          end else if (req != 4'b0000) begin
            // Handoff on the same edge keeps the mux busy with no dead cycle.
            owner_d = winner;
            last_d  = winner;
            cnt_d   = CNT_ONE;
            grant_d = 4'b0001 << winner;
          end else begin
            state_d = IDLE;
            owner_d = 2'd0;
            cnt_d   = '0;
            grant_d = 4'b0000;
          end
        end
        default: begin
          state_d = IDLE;
          owner_d = 2'd0;
          cnt_d   = '0;
          grant_d = 4'b0000;
        end
      endcase
    end
  end

  // last_q resets to 3 so the first arbitration after reset favours requester 0.
  always_ff @(posedge clock_in or posedge reset_signal) begin
    if (reset_signal) begin
      state_q <= IDLE;
      owner_q <= 2'd0;
      last_q  <= 2'd3;
      cnt_q   <= '0;
      grant_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
    end
  end

  assign grant        = grant_q;
  assign mux_select   = owner_q;
  assign busy         = (state_q == GRANT);
  assign mux_enable   = busy && enable_signal;
  assign owner_cycles = cnt_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Randomized and directed bench for mux4_rr_arbiter.
// A reference model feeds an expected queue, and a monitor checks the DUT after every posedge.
module tb_mux4_rr_arbiter;
  localparam int MAXH = 4;
  localparam int CW   = 8;
  localparam int W    = 4 + 2 + 1 + 1 + CW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic [3:0]    req = 4'b0000;
  logic [3:0]    grant;
  logic [1:0]    mux_select;
  logic          mux_enable;
  logic          busy;
  logic [CW-1:0] owner_cycles;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state, kept as plain integers.
  int m_active = 0;
  int m_owner  = 0;
  int m_cnt    = 0;
  int m_last   = 3;

  mux4_rr_arbiter #(.MAX_HOLD(MAXH), .CNT_W(CW)) dut (
    .clock_in(clk), .reset_signal(rst), .enable_signal(en), .req(req),
    .grant(grant), .mux_select(mux_select), .mux_enable(mux_enable),
    .busy(busy), .owner_cycles(owner_cycles)
  );

  // Clock and reset
  always #5 clk = ~clk;

  function automatic int pick(input int b, input logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      if (r[(b + k) % 4]) return (b + k) % 4;
    end
    return b;
  endfunction

  function automatic logic [W-1:0] model_out(input logic e);
    logic [3:0] g;
    logic [1:0] s;
    g = m_active ? 4'(1 << m_owner) : 4'b0000;
    s = m_active ? 2'(m_owner) : 2'd0;
    return {g, s, 1'(m_active != 0 && e), 1'(m_active != 0), CW'(m_cnt)};
  endfunction

  task automatic model_reset();
    m_active = 0; m_owner = 0; m_cnt = 0; m_last = 3;
  endtask

  task automatic model_step(input logic [3:0] r, input logic e);
    int w;
    if (!e) return;
    if (m_active == 0) begin
      if (r != 0) begin
        w = pick(m_last, r);
        m_active = 1; m_owner = w; m_cnt = 1; m_last = w;
      end
    end else if (r[m_owner] && !(MAXH != 0 && m_cnt == MAXH)) begin
      if (m_cnt < (1 << CW) - 1) m_cnt++;
    end else if (r != 0) begin
      w = pick(m_owner, r);
      m_owner = w; m_cnt = 1; m_last = w;
    end else begin
      m_active = 0; m_owner = 0; m_cnt = 0;
    end
  endtask

  function automatic logic [W-1:0] dut_out();
    return {grant, mux_select, mux_enable, busy, owner_cycles};
  endfunction

  // Driver: one call per clock, inputs applied on the negedge.
  task automatic cycle(input logic [3:0] r, input logic e, input logic rs);
    logic [W-1:0] got;
    @(negedge clk);
    req = r; en = e; rst = rs;
    if (rs) begin
      model_reset();
      #1;
      got = dut_out();
      checks++;
      if (got !== model_out(e)) begin
        errors++;
        $display("FAIL async_reset: got %h required %h", got, model_out(e));
      end
    end else begin
      model_step(r, e);
    end
    exp_q.push_back(model_out(e));
  endtask

  // Monitor / scoreboard
  initial begin
    logic [W-1:0] exp_v, got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        got = dut_out();
        checks++;
        if (got !== exp_v) begin
          errors++;
          $display("FAIL out_chk t=%0t: got grant=%b sel=%0d men=%b busy=%b cyc=%0d required grant=%b sel=%0d men=%b busy=%b cyc=%0d",
                   $time, got[W-1 -: 4], got[W-5 -: 2], got[CW+1], got[CW], got[CW-1:0],
                   exp_v[W-1 -: 4], exp_v[W-5 -: 2], exp_v[CW+1], exp_v[CW], exp_v[CW-1:0]);
        end
      end
    end
  end

  initial begin
    logic [3:0] r;
    logic e;
    // Reset state, then a single request from requester 2.
    repeat (2) cycle(4'b0000, 1'b0, 1'b1);
    cycle(4'b0100, 1'b1, 1'b0);
    repeat (3) cycle(4'b0100, 1'b1, 1'b0);
    // All requesting: rotation with hold limit and no idle cycle.
    cycle(4'b0000, 1'b1, 1'b1);
    repeat (22) cycle(4'b1111, 1'b1, 1'b0);
    // Owner 0 drops while 1 requests: immediate handoff.
    cycle(4'b0000, 1'b1, 1'b1);
    repeat (2) cycle(4'b0011, 1'b1, 1'b0);
    repeat (2) cycle(4'b0010, 1'b1, 1'b0);
    cycle(4'b0000, 1'b1, 1'b0);
    // Owner 2 frozen by enable low for 3 cycles.
    cycle(4'b0000, 1'b1, 1'b1);
    repeat (2) cycle(4'b0100, 1'b1, 1'b0);
    repeat (3) cycle(4'b0100, 1'b0, 1'b0);
    repeat (3) cycle(4'b0100, 1'b1, 1'b0);
    // Sole requester 3 is re-granted at timeout.
    cycle(4'b0000, 1'b1, 1'b1);
    repeat (12) cycle(4'b1000, 1'b1, 1'b0);
    // Reset mid-grant of owner 1, then restart from requester 0.
    cycle(4'b0000, 1'b1, 1'b1);
    cycle(4'b0010, 1'b1, 1'b0);
    repeat (2) cycle(4'b1111, 1'b1, 1'b0);
    cycle(4'b1111, 1'b1, 1'b1);
    repeat (3) cycle(4'b1111, 1'b1, 1'b0);
    // Randomized traffic.
    r = 4'b0000;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 9) < 3) r = 4'($urandom_range(0, 15));
      e = ($urandom_range(0, 9) != 0);
      cycle(r, e, ($urandom_range(0, 99) == 0));
    end
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 4-input 32-bit negedge-sampled multiplexer.
- Four requesters compete for the mux. The block grants one of them at a time.
- It drives the mux `select[1:0]` and its enable from posedge-registered state, so both are stable at the mux's sampling negedge.
- It bounds each tenure with a configurable hold limit, then hands off with zero dead cycles.

Parameters:
- MAX_HOLD, 8, maximum enabled cycles one owner may keep the grant; 0 = unlimited (release only on request drop).
- CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clock_in  input  1  system clock; all state updates on posedge.
- reset_signal  input  1  asynchronous, active-high reset.
- enable_signal  input  1  global run enable; low freezes the arbiter.
- req  input  4  per-requester request; held high for as long as ownership is wanted.
- grant  output  4  one-hot grant, registered; 0 when idle.
- mux_select  output  2  index of current owner; drives mux select.
- mux_enable  output  1  drives mux enable; high only while granted and enable_signal high.
- busy  output  1  high when state is GRANT.
- owner_cycles  output  CNT_W  enabled cycles consumed by the current owner, for debug.

Behaviour:
- Reset (async, immediate): grant=0, mux_select=0, mux_enable=0, busy=0, owner_cycles=0, state=IDLE, last_owner=3. The first arbitration therefore favours requester 0.
- Priority order:
  - Search starts at last_owner+1 (mod 4), i.e. last_owner+1, +2, +3, then last_owner itself.
  - The first index with req high wins.
  - Ties are impossible; the order is fully defined.
- State IDLE:
  - On posedge with enable_signal=1 and req!=0: the winner is registered.
  - Next cycle: grant=one-hot(winner), mux_select=winner, mux_enable=1, busy=1, owner_cycles=1, state=GRANT, last_owner=winner.
  - Latency from req rising to grant: 1 posedge.
  - With req=0 or enable_signal=0: remain IDLE, all outputs 0.
- State GRANT, evaluated at each posedge with enable_signal=1:
  - Release condition: req[owner]==0, OR (MAX_HOLD!=0 AND owner_cycles==MAX_HOLD).
  - No release: owner_cycles increments, saturating at 2^CNT_W-1 when MAX_HOLD=0. Grant is unchanged.
  - Release with req!=0: the winner is chosen per the priority order from the current owner.
    - On timeout, other requesters win before the owner.
    - The owner is re-granted only if it is the sole requester.
    - The new grant appears on the same posedge, with no idle cycle. owner_cycles=1, last_owner=winner.
  - Release with req==0: go to IDLE. grant=0, mux_enable=0, busy=0, owner_cycles=0. last_owner keeps the released owner.
- enable_signal=0:
  - The FSM, owner_cycles and grant are held.
  - mux_enable is forced to 0 combinationally from the registered grant-active bit ANDed with enable_signal.
  - mux_select is held.
  - Request changes during the freeze are evaluated only on the first enabled posedge.
- Requester dropping and re-raising req within the same tenure: a drop seen at any enabled posedge releases.
- Reset asserted mid-GRANT: outputs go to reset values immediately. After deassertion, arbitration restarts from requester 0.
- grant is always one-hot or zero. mux_select is always equal to the index of the grant bit while busy=1.

Test Plan:
- MAX_HOLD=8, reset released, req=4'b0100 at cycle 0 -> cycle 1: grant=4'b0100, mux_select=2, mux_enable=1, busy=1, owner_cycles=1.
- MAX_HOLD=4, req=4'b1111 held -> grants 0,1,2,3,0 each for exactly 4 consecutive cycles, with no cycle where grant=0.
- Owner 0 granted, req=4'b0011, then req[0] drops -> next posedge grant=4'b0010, mux_select=1, owner_cycles=1.
- Granted owner 2, enable_signal low for 3 cycles -> mux_enable=0 and owner_cycles frozen at its value for those 3 cycles, grant=4'b0100 held. Counting resumes when enable_signal returns high.
- MAX_HOLD=4, only req[3] high -> at timeout grant stays 4'b1000, owner_cycles returns to 1, mux_enable never drops.
- Reset_signal pulsed mid-grant of owner 1 with req=4'b1111 -> outputs 0 asynchronously. The first grant after release is 4'b0001.
